// File: rtl/deemph_pkg.sv
// Shared types and fixed-point helpers for the FM de-emphasis IIR filter.
// All samples and coefficients are signed Q10 in 32-bit words.
package deemph_pkg;

    localparam int QUANT_BITS   = 10;
    localparam int SAMPLE_WIDTH = 32;

    localparam logic signed [SAMPLE_WIDTH-1:0] X0_COEFF_DEFAULT = 178;
    localparam logic signed [SAMPLE_WIDTH-1:0] X1_COEFF_DEFAULT = 178;
    localparam logic signed [SAMPLE_WIDTH-1:0] Y1_COEFF_DEFAULT = -666;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WRITE
    } state_t;

    // Full-precision product, then floor-shift back to Q10 and keep the low word.
    function automatic logic signed [SAMPLE_WIDTH-1:0] deq(
        input logic signed [SAMPLE_WIDTH-1:0] coeff,
        input logic signed [SAMPLE_WIDTH-1:0] x
    );
        logic signed [2*SAMPLE_WIDTH-1:0] p;
        p = (2*SAMPLE_WIDTH)'(coeff) * (2*SAMPLE_WIDTH)'(x);
        return SAMPLE_WIDTH'(p >>> QUANT_BITS);
    endfunction

endpackage

// File: rtl/deemph_iir_core.sv
// De-emphasis recurrence y[n] = deq(X0*x[n]) + deq(X1*x[n-1]) + deq(Y1*y[n-1]),
// one sample per three clocks, sequenced by an IDLE/CALC/WRITE FSM between two FIFOs.
module deemph_iir_core
    import deemph_pkg::*;
#(
    parameter int                               DATA_WIDTH = SAMPLE_WIDTH,
    parameter logic signed [SAMPLE_WIDTH-1:0]   X0_COEFF   = X0_COEFF_DEFAULT,
    parameter logic signed [SAMPLE_WIDTH-1:0]   X1_COEFF   = X1_COEFF_DEFAULT,
    parameter logic signed [SAMPLE_WIDTH-1:0]   Y1_COEFF   = Y1_COEFF_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    state_t state;
    state_t next_state;

    logic signed [DATA_WIDTH-1:0] x_reg;
    logic signed [DATA_WIDTH-1:0] x_prev;
    logic signed [DATA_WIDTH-1:0] y_prev;
    logic signed [DATA_WIDTH-1:0] p_x0;
    logic signed [DATA_WIDTH-1:0] p_x1;
    logic signed [DATA_WIDTH-1:0] p_y1;
    logic signed [DATA_WIDTH-1:0] sum;

    assign sum     = p_x0 + p_x1 + p_y1;
    assign out_din = sum;

    always_comb begin
        next_state = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_empty) begin
                    in_rd_en   = 1'b1;
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                next_state = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Products load only in CALC, so a stall in WRITE keeps the pending result intact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            x_reg  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            p_x0   <= '0;
            p_x1   <= '0;
            p_y1   <= '0;
        end else begin
            state <= next_state;
            if (in_rd_en) begin
                x_reg <= in_dout;
            end
            if (state == S_CALC) begin
                p_x0 <= deq(X0_COEFF, x_reg);
                p_x1 <= deq(X1_COEFF, x_prev);
                p_y1 <= deq(Y1_COEFF, y_prev);
            end
            if (out_wr_en) begin
                x_prev <= x_reg;
                y_prev <= sum;
            end
        end
    end

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO shared by the audio stages; dout shows the head entry.
// Full/empty compare both pointers directly, so wr_clk and rd_clk must be the same clock.
module fifo #(
    parameter int FIFO_DATA_WIDTH  = 32,
    parameter int FIFO_BUFFER_SIZE = 256
) (
    input  logic                       reset,
    input  logic                       wr_clk,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din,
    output logic                       full,
    input  logic                       rd_clk,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout,
    output logic                       empty
);

    localparam int ADDR_WIDTH = $clog2(FIFO_BUFFER_SIZE);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
    logic [ADDR_WIDTH:0]        wr_ptr;
    logic [ADDR_WIDTH:0]        rd_ptr;
    logic                       do_write;
    logic                       do_read;

    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (do_read) begin
            rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    // Extra pointer bit distinguishes a wrapped (full) buffer from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign dout  = mem[rd_ptr[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/deemph_iir_top.sv
// FM de-emphasis stage: input FIFO -> IIR core -> output FIFO, all on one clock.
// Signed Q10 samples; the output FIFO feeds the downstream gain stage.
module deemph_iir_top
    import deemph_pkg::*;
#(
    parameter int                             DATA_WIDTH       = SAMPLE_WIDTH,
    parameter int                             FIFO_BUFFER_SIZE = 256,
    parameter logic signed [SAMPLE_WIDTH-1:0] X0_COEFF         = X0_COEFF_DEFAULT,
    parameter logic signed [SAMPLE_WIDTH-1:0] X1_COEFF         = X1_COEFF_DEFAULT,
    parameter logic signed [SAMPLE_WIDTH-1:0] Y1_COEFF         = Y1_COEFF_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_din,
    input  logic                  in_wr_en,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] out_dout,
    input  logic                  out_rd_en,
    output logic                  out_empty
);

    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;
    logic                  out_wr_en;

    fifo #(
        .FIFO_DATA_WIDTH  (DATA_WIDTH),
        .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
    ) in_fifo (
        .reset  (reset),
        .wr_clk (clock),
        .wr_en  (in_wr_en),
        .din    (in_din),
        .full   (in_full),
        .rd_clk (clock),
        .rd_en  (in_rd_en),
        .dout   (in_dout),
        .empty  (in_empty)
    );

    deemph_iir_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .X0_COEFF   (X0_COEFF),
        .X1_COEFF   (X1_COEFF),
        .Y1_COEFF   (Y1_COEFF)
    ) core (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    fifo #(
        .FIFO_DATA_WIDTH  (DATA_WIDTH),
        .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
    ) out_fifo (
        .reset  (reset),
        .wr_clk (clock),
        .wr_en  (out_wr_en),
        .din    (out_din),
        .full   (out_full),
        .rd_clk (clock),
        .rd_en  (out_rd_en),
        .dout   (out_dout),
        .empty  (out_empty)
    );

endmodule
